// File: rtl/vga_mode_controller.sv
// Video mode table and sequenced reconfiguration controller for the VGA timing generator.
// Mode changes are taken at a frame boundary and replayed through reset, clock lock and blanking.
module vga_mode_controller #(
    parameter int         H_WIDTH      = 11,
    parameter int         V_WIDTH      = 11,
    parameter int         PORCH_WIDTH  = 9,
    parameter int         DEFAULT_MODE = 0,
    parameter logic [6:0] MODE_MASK    = 7'h7F,
    parameter int         LOCK_STABLE  = 16,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         BLANK_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             sel,
    input  logic                   sel_valid,
    output logic                   sel_ready,
    input  logic                   frame_start,
    input  logic                   pclk_locked,
    output logic [H_WIDTH-1:0]     h_active,
    output logic [PORCH_WIDTH-1:0] h_fp,
    output logic [PORCH_WIDTH-1:0] h_sync,
    output logic [PORCH_WIDTH-1:0] h_bp,
    output logic [V_WIDTH-1:0]     v_active,
    output logic [PORCH_WIDTH-1:0] v_fp,
    output logic [PORCH_WIDTH-1:0] v_sync,
    output logic [PORCH_WIDTH-1:0] v_bp,
    output logic                   hs_pol,
    output logic                   vs_pol,
    output logic [2:0]             pclk_sel,
    output logic [3:0]             mode_id,
    output logic                   tg_rst,
    output logic                   video_en,
    output logic                   busy,
    output logic                   sel_err
);

    localparam int LW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [2:0] DEF   = 3'(DEFAULT_MODE);
    localparam logic [7:0] MASK8 = {1'b0, MODE_MASK};

    // Entry 7 mirrors mode 0 so a 3-bit index never falls off the table.
    localparam int T_HA [8] = '{640, 800, 1024, 1280, 1280, 1600, 1920, 640};
    localparam int T_HF [8] = '{16, 40, 24, 110, 48, 64, 88, 16};
    localparam int T_HS [8] = '{96, 128, 136, 40, 112, 192, 44, 96};
    localparam int T_HB [8] = '{48, 88, 160, 220, 248, 304, 148, 48};
    localparam int T_VA [8] = '{480, 600, 768, 720, 1024, 1200, 1080, 480};
    localparam int T_VF [8] = '{10, 1, 3, 5, 1, 1, 4, 10};
    localparam int T_VS [8] = '{2, 4, 6, 5, 3, 3, 5, 2};
    localparam int T_VB [8] = '{33, 23, 29, 20, 38, 46, 36, 33};
    localparam logic [7:0] T_POL = 8'b0111_1010;

    typedef enum logic [1:0] {
        S_RECONF,
        S_BLANK,
        S_RUN,
        S_WAIT_FRAME
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [LW-1:0]   r_lock_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [BW-1:0]   r_blank_cnt;
    logic [2:0]      r_mode;
    logic [2:0]      r_pending;
    logic            r_sel_err;
    logic            w_lock_done;
    logic            w_timeout;
    logic            w_frame_done;
    logic            w_fire;
    logic            w_sel_ok;
    logic            w_change;
    logic            w_apply;
    logic            w_load;
    logic [2:0]      w_idx;

    assign w_lock_done  = (r_state == S_RECONF) && pclk_locked
                          && (r_lock_cnt == LW'(LOCK_STABLE - 1));
    assign w_timeout    = (r_state == S_RECONF) && !w_lock_done
                          && (r_to_cnt == TW'(LOCK_TIMEOUT - 1));
    assign w_frame_done = (r_state == S_BLANK) && frame_start
                          && (r_blank_cnt == BW'(BLANK_FRAMES - 1));
    assign w_fire       = sel_valid && (r_state == S_RUN);
    assign w_sel_ok     = !sel[3] && MASK8[sel[2:0]];
    assign w_change     = w_fire && w_sel_ok && (sel[2:0] != r_mode);
    assign w_apply      = (r_state == S_WAIT_FRAME) && frame_start;
    assign w_load       = w_apply || w_timeout;
    assign w_idx        = (w_apply && !rst) ? r_pending : DEF;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RECONF;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RECONF: begin
                if (w_lock_done)
                    w_next = (BLANK_FRAMES == 0) ? S_RUN : S_BLANK;
            end
            S_BLANK: begin
                if (w_frame_done) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_change) w_next = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (frame_start) w_next = S_RECONF;
            end
            default: w_next = S_RECONF;
        endcase
    end

    always_comb begin
        tg_rst    = 1'b0;
        video_en  = 1'b0;
        sel_ready = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            S_RECONF:     tg_rst = 1'b1;
            S_BLANK:      tg_rst = 1'b0;
            S_RUN: begin
                video_en  = 1'b1;
                sel_ready = 1'b1;
                busy      = 1'b0;
            end
            S_WAIT_FRAME: video_en = 1'b1;
            default:      tg_rst = 1'b1;
        endcase
    end

    // A timeout restarts the lock wait from scratch.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_RECONF || w_timeout) begin
            r_lock_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_to_cnt   <= r_to_cnt + TW'(1);
            r_lock_cnt <= pclk_locked ? r_lock_cnt + LW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != S_BLANK) r_blank_cnt <= '0;
        else if (frame_start)          r_blank_cnt <= r_blank_cnt + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)           r_pending <= DEF;
        else if (w_change) r_pending <= sel[2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) r_sel_err <= 1'b0;
        else     r_sel_err <= w_timeout || (w_fire && !w_sel_ok);
    end

    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_mode   <= w_idx;
            h_active <= H_WIDTH'(T_HA[w_idx]);
            h_fp     <= PORCH_WIDTH'(T_HF[w_idx]);
            h_sync   <= PORCH_WIDTH'(T_HS[w_idx]);
            h_bp     <= PORCH_WIDTH'(T_HB[w_idx]);
            v_active <= V_WIDTH'(T_VA[w_idx]);
            v_fp     <= PORCH_WIDTH'(T_VF[w_idx]);
            v_sync   <= PORCH_WIDTH'(T_VS[w_idx]);
            v_bp     <= PORCH_WIDTH'(T_VB[w_idx]);
            hs_pol   <= T_POL[w_idx];
            vs_pol   <= T_POL[w_idx];
        end
    end

    assign mode_id  = {1'b0, r_mode};
    assign pclk_sel = r_mode;
    assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_vga_mode_controller.sv
// Directed bench for vga_mode_controller: bring-up, mode changes, errors, lock loss, timeout, reset.
// Mode 5 is masked off and the lock timeout shortened to 100 cycles.
module tb_vga_mode_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic        sel_valid;
    logic        sel_ready;
    logic        frame_start;
    logic        pclk_locked;
    logic [10:0] h_active;
    logic [8:0]  h_fp, h_sync, h_bp;
    logic [10:0] v_active;
    logic [8:0]  v_fp, v_sync, v_bp;
    logic        hs_pol, vs_pol;
    logic [2:0]  pclk_sel;
    logic [3:0]  mode_id;
    logic        tg_rst, video_en, busy, sel_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_mode_controller #(
        .MODE_MASK    (7'h5F),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .frame_start (frame_start),
        .pclk_locked (pclk_locked),
        .h_active    (h_active),
        .h_fp        (h_fp),
        .h_sync      (h_sync),
        .h_bp        (h_bp),
        .v_active    (v_active),
        .v_fp        (v_fp),
        .v_sync      (v_sync),
        .v_bp        (v_bp),
        .hs_pol      (hs_pol),
        .vs_pol      (vs_pol),
        .pclk_sel    (pclk_sel),
        .mode_id     (mode_id),
        .tg_rst      (tg_rst),
        .video_en    (video_en),
        .busy        (busy),
        .sel_err     (sel_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic request(input logic [3:0] s);
        sel       = s;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    // 16 locked cycles, then two frames of blanking.
    task automatic bring_up(input string tag);
        pclk_locked = 1'b1;
        repeat (16) tick();
        total++;
        if (tg_rst !== 1'b0) begin
            bad++;
            $display("FAIL %s_lock tg_rst=%b exp=0", tag, tg_rst);
        end
        pulse_frame();
        tick();
        pulse_frame();
        total++;
        if ({video_en, sel_ready, busy} !== 3'b110) begin
            bad++;
            $display("FAIL %s_run en/rdy/busy=%b exp=110", tag,
                     {video_en, sel_ready, busy});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sel = 4'd0; sel_valid = 1'b0;
        frame_start = 1'b0; pclk_locked = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({tg_rst, video_en, sel_ready, busy, sel_err} !== 5'b10010) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=10010",
                     {tg_rst, video_en, sel_ready, busy, sel_err});
        end
        total++;
        if ({mode_id, pclk_sel} !== {4'd0, 3'd0}) begin
            bad++;
            $display("FAIL reset_mode mode=%0d pclk=%0d exp=0/0", mode_id, pclk_sel);
        end
        total++;
        if ({h_active, h_fp, h_sync, h_bp} !== {11'd640, 9'd16, 9'd96, 9'd48}) begin
            bad++;
            $display("FAIL reset_h got=%0d/%0d/%0d/%0d exp=640/16/96/48",
                     h_active, h_fp, h_sync, h_bp);
        end
        total++;
        if ({v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol} !==
            {11'd480, 9'd10, 9'd2, 9'd33, 2'b00}) begin
            bad++;
            $display("FAIL reset_v got=%0d/%0d/%0d/%0d pol=%b%b exp=480/10/2/33 00",
                     v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol);
        end
    endtask

    task automatic test_bringup;
        int early;
        early = 0;
        pclk_locked = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (tg_rst !== 1'b1) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL bringup_hold early_release=%0d exp=0", early);
        end
        tick();
        total++;
        if ({tg_rst, video_en, busy} !== 3'b001) begin
            bad++;
            $display("FAIL bringup_blank rst/en/busy=%b exp=001",
                     {tg_rst, video_en, busy});
        end
        pulse_frame();
        total++;
        if (video_en !== 1'b0) begin
            bad++;
            $display("FAIL bringup_frame1 video_en=%b exp=0", video_en);
        end
        tick();
        pulse_frame();
        total++;
        if ({video_en, sel_ready, busy, tg_rst} !== 4'b1100) begin
            bad++;
            $display("FAIL bringup_run en/rdy/busy/rst=%b exp=1100",
                     {video_en, sel_ready, busy, tg_rst});
        end
        total++;
        if ({h_active, v_active, mode_id} !== {11'd640, 11'd480, 4'd0}) begin
            bad++;
            $display("FAIL bringup_mode h=%0d v=%0d mode=%0d exp=640/480/0",
                     h_active, v_active, mode_id);
        end
    endtask

    task automatic test_mode_change;
        request(4'd6);
        total++;
        if ({sel_ready, video_en, busy} !== 3'b011 || h_active !== 11'd640
            || mode_id !== 4'd0) begin
            bad++;
            $display("FAIL wait_hold rdy/en/busy=%b h=%0d mode=%0d exp=011/640/0",
                     {sel_ready, video_en, busy}, h_active, mode_id);
        end
        repeat (3) tick();
        total++;
        if (h_active !== 11'd640 || pclk_sel !== 3'd0) begin
            bad++;
            $display("FAIL wait_unchanged h=%0d pclk=%0d exp=640/0", h_active, pclk_sel);
        end
        pulse_frame();
        total++;
        if ({h_active, h_fp, h_sync, h_bp} !== {11'd1920, 9'd88, 9'd44, 9'd148}) begin
            bad++;
            $display("FAIL mode6_h got=%0d/%0d/%0d/%0d exp=1920/88/44/148",
                     h_active, h_fp, h_sync, h_bp);
        end
        total++;
        if ({v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol} !==
            {11'd1080, 9'd4, 9'd5, 9'd36, 2'b11}) begin
            bad++;
            $display("FAIL mode6_v got=%0d/%0d/%0d/%0d pol=%b%b exp=1080/4/5/36 11",
                     v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol);
        end
        total++;
        if ({pclk_sel, mode_id, tg_rst, video_en, busy} !== {3'd6, 4'd6, 3'b101}) begin
            bad++;
            $display("FAIL mode6_ctl pclk=%0d mode=%0d rst/en/busy=%b exp=6/6/101",
                     pclk_sel, mode_id, {tg_rst, video_en, busy});
        end
        bring_up("mode6");
    endtask

    task automatic test_sel_errors;
        request(4'd9);
        total++;
        if (sel_err !== 1'b1 || mode_id !== 4'd6 || sel_ready !== 1'b1) begin
            bad++;
            $display("FAIL err_range err=%b mode=%0d rdy=%b exp=1/6/1",
                     sel_err, mode_id, sel_ready);
        end
        tick();
        total++;
        if (sel_err !== 1'b0) begin
            bad++;
            $display("FAIL err_width err=%b exp=0", sel_err);
        end
        request(4'd5);
        total++;
        if (sel_err !== 1'b1 || mode_id !== 4'd6 || sel_ready !== 1'b1) begin
            bad++;
            $display("FAIL err_mask err=%b mode=%0d rdy=%b exp=1/6/1",
                     sel_err, mode_id, sel_ready);
        end
        request(4'd7);
        total++;
        if (sel_err !== 1'b1 || mode_id !== 4'd6) begin
            bad++;
            $display("FAIL err_seven err=%b mode=%0d exp=1/6", sel_err, mode_id);
        end
        request(4'd6);
        total++;
        if ({sel_err, sel_ready, busy, video_en} !== 4'b0101 || mode_id !== 4'd6) begin
            bad++;
            $display("FAIL same_mode err/rdy/busy/en=%b mode=%0d exp=0101/6",
                     {sel_err, sel_ready, busy, video_en}, mode_id);
        end
    endtask

    task automatic test_lock_drop;
        int early;
        early = 0;
        request(4'd1);
        pulse_frame();
        total++;
        if ({h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp} !==
            {11'd800, 9'd40, 9'd128, 9'd88, 11'd600, 9'd1, 9'd4, 9'd23}
            || {hs_pol, vs_pol} !== 2'b11) begin
            bad++;
            $display("FAIL mode1_tbl h=%0d/%0d/%0d/%0d v=%0d/%0d/%0d/%0d pol=%b%b",
                     h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp,
                     hs_pol, vs_pol);
        end
        repeat (10) tick();
        pclk_locked = 1'b0;
        tick();
        pclk_locked = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (tg_rst !== 1'b1) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL lockdrop_hold early_release=%0d exp=0", early);
        end
        tick();
        total++;
        if (tg_rst !== 1'b0) begin
            bad++;
            $display("FAIL lockdrop_release tg_rst=%b exp=0", tg_rst);
        end
        bring_up("mode1");
    endtask

    task automatic test_timeout;
        int spurious;
        spurious = 0;
        request(4'd3);
        pclk_locked = 1'b0;
        pulse_frame();
        total++;
        if ({h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp} !==
            {11'd1280, 9'd110, 9'd40, 9'd220, 11'd720, 9'd5, 9'd5, 9'd20}
            || mode_id !== 4'd3) begin
            bad++;
            $display("FAIL mode3_tbl h=%0d/%0d/%0d/%0d v=%0d/%0d/%0d/%0d mode=%0d",
                     h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp,
                     mode_id);
        end
        for (int i = 1; i < 100; i++) begin
            tick();
            if (sel_err !== 1'b0 || mode_id !== 4'd3) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL timeout_early count=%0d exp=0", spurious);
        end
        tick();
        total++;
        if ({sel_err, tg_rst, video_en} !== 3'b110 || mode_id !== 4'd0
            || h_active !== 11'd640) begin
            bad++;
            $display("FAIL timeout_fire err/rst/en=%b mode=%0d h=%0d exp=110/0/640",
                     {sel_err, tg_rst, video_en}, mode_id, h_active);
        end
        spurious = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sel_err !== 1'b0 || tg_rst !== 1'b1) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL timeout_restart count=%0d exp=0", spurious);
        end
        bring_up("timeout");
    endtask

    task automatic test_reset_blank;
        request(4'd2);
        pclk_locked = 1'b1;
        pulse_frame();
        repeat (16) tick();
        total++;
        if (tg_rst !== 1'b0 || mode_id !== 4'd2) begin
            bad++;
            $display("FAIL blank_entry tg_rst=%b mode=%0d exp=0/2", tg_rst, mode_id);
        end
        pulse_frame();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({tg_rst, video_en, sel_ready, busy, sel_err} !== 5'b10010
            || mode_id !== 4'd0 || h_active !== 11'd640) begin
            bad++;
            $display("FAIL rst_blank ctl=%b mode=%0d h=%0d exp=10010/0/640",
                     {tg_rst, video_en, sel_ready, busy, sel_err}, mode_id, h_active);
        end
        pulse_frame();
        total++;
        if ({tg_rst, video_en} !== 2'b10) begin
            bad++;
            $display("FAIL rst_blank_frame rst/en=%b exp=10", {tg_rst, video_en});
        end
        bring_up("rstblank");
    endtask

    task automatic test_reset_wait;
        request(4'd4);
        total++;
        if (sel_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rstwait_pending rdy=%b busy=%b exp=0/1", sel_ready, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({tg_rst, video_en, sel_ready} !== 3'b100 || mode_id !== 4'd0) begin
            bad++;
            $display("FAIL rst_wait rst/en/rdy=%b mode=%0d exp=100/0",
                     {tg_rst, video_en, sel_ready}, mode_id);
        end
        bring_up("rstwait");
        total++;
        if (mode_id !== 4'd0 || h_active !== 11'd640 || v_active !== 11'd480) begin
            bad++;
            $display("FAIL rstwait_lost mode=%0d h=%0d v=%0d exp=0/640/480",
                     mode_id, h_active, v_active);
        end
    endtask

    task automatic test_back_to_back;
        request(4'd2);
        request(4'd4);
        total++;
        if (sel_ready !== 1'b0 || mode_id !== 4'd0 || sel_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wait rdy=%b mode=%0d err=%b exp=0/0/0",
                     sel_ready, mode_id, sel_err);
        end
        pulse_frame();
        total++;
        if ({h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp} !==
            {11'd1024, 9'd24, 9'd136, 9'd160, 11'd768, 9'd3, 9'd6, 9'd29}
            || {hs_pol, vs_pol} !== 2'b00 || mode_id !== 4'd2) begin
            bad++;
            $display("FAIL b2b_mode2 h=%0d/%0d/%0d/%0d v=%0d/%0d/%0d/%0d mode=%0d",
                     h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp,
                     mode_id);
        end
        bring_up("b2b");
        total++;
        if (mode_id !== 4'd2) begin
            bad++;
            $display("FAIL b2b_final mode=%0d exp=2", mode_id);
        end
        request(4'd4);
        pulse_frame();
        total++;
        if ({h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp} !==
            {11'd1280, 9'd48, 9'd112, 9'd248, 11'd1024, 9'd1, 9'd3, 9'd38}
            || {hs_pol, vs_pol} !== 2'b11 || pclk_sel !== 3'd4) begin
            bad++;
            $display("FAIL mode4_tbl h=%0d/%0d/%0d/%0d v=%0d/%0d/%0d/%0d pclk=%0d",
                     h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp,
                     pclk_sel);
        end
        bring_up("mode4");
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_mode_change();
        test_sel_errors();
        test_lock_drop();
        test_timeout();
        test_reset_blank();
        test_reset_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
